// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and helpers for the multi-port register file
package rf_pkg;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    // One register resets/clears to all ones; the rest go to zero.
    // Returns the fill bit; callers replicate it to the data width.
    function automatic logic rf_reset_val(input int idx, input int ones_idx);
        return (idx == ones_idx);
    endfunction

endpackage

// File: rtl/rf_multiport_if.sv
// rtl/rf_multiport_if.sv - write/read/clear bus of the multi-port register file
interface rf_multiport_if #(
    parameter int N       = 8,
    parameter int AW      = 2,
    parameter int NUM_RD  = 2,
    parameter int NUM_SRC = 3,
    parameter int SW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
    logic                           write_en;
    logic [AW-1:0]                  write_addr;
    logic [SW-1:0]                  select_src;
    logic [NUM_SRC-1:0][N-1:0]      src_data;
    logic [NUM_RD-1:0]              read_en;
    logic [NUM_RD-1:0][AW-1:0]      read_addr;
    logic [NUM_RD-1:0]              select_dest;
    logic [NUM_RD-1:0][N-1:0]       dest1;
    logic [NUM_RD-1:0][N-1:0]       dest2;
    logic [NUM_RD-1:0]              rd_valid;
    logic                           clear_req;
    logic                           clear_busy;
    logic                           clear_done;

    modport master (
        output write_en, write_addr, select_src, src_data,
        output read_en, read_addr, select_dest, clear_req,
        input  dest1, dest2, rd_valid, clear_busy, clear_done
    );

    modport slave (
        input  write_en, write_addr, select_src, src_data,
        input  read_en, read_addr, select_dest, clear_req,
        output dest1, dest2, rd_valid, clear_busy, clear_done
    );
endinterface

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - registered read port with optional bypass (RF_BYPASS_EN) and dest steering
module rf_read_port #(
    parameter int N  = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    input  logic          i_sel_dest,
    input  logic [N-1:0]  i_rd_data,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [N-1:0]  i_wr_data,
    output logic [N-1:0]  o_dest1,
    output logic [N-1:0]  o_dest2,
    output logic          o_rd_valid
);
    logic [N-1:0] w_data;
    logic [N-1:0] r_dest1;
    logic [N-1:0] r_dest2;
    logic         r_rd_valid;

`ifdef RF_BYPASS_EN
    // i_wr_en is only high for accepted writes, so clears never forward.
    assign w_data = (i_wr_en && (i_wr_addr == i_rd_addr)) ? i_wr_data : i_rd_data;
`else
    logic w_unused_wr;
    assign w_unused_wr = ^{i_wr_en, i_wr_addr, i_wr_data};
    assign w_data      = i_rd_data;
`endif

    // Capture read data into the selected destination; idle cycles hold the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dest1    <= '0;
            r_dest2    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_dest1 <= i_sel_dest ? '0 : w_data;
                r_dest2 <= i_sel_dest ? w_data : '0;
            end
        end
    end

    assign o_dest1    = r_dest1;
    assign o_dest2    = r_dest2;
    assign o_rd_valid = r_rd_valid;
endmodule

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - multi-port register file with clear engine; RF_BYPASS_EN enables write-to-read bypass
module rf_multiport
    import rf_pkg::*;
#(
    parameter int N        = 8,
    parameter int AW       = 2,
    parameter int NUM_RD   = 2,
    parameter int NUM_SRC  = 3,
    parameter int ONES_IDX = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    rf_multiport_if.slave bus
);
    localparam int DEPTH = 2 ** AW;
    localparam int SW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    rf_state_e                r_state;
    rf_state_e                w_next_state;
    logic [AW-1:0]            r_clr_ptr;
    logic [DEPTH-1:0][N-1:0]  r_q;
    logic                     w_clr_last;
    logic                     w_wr_accept;
    logic [N-1:0]             w_wr_data;
    logic [NUM_RD-1:0][N-1:0] w_rd_data;

    assign w_clr_last = (r_clr_ptr == AW'(DEPTH - 1));

    // Write source mux; an out-of-range select matches nothing and stores zero.
    always_comb begin
        w_wr_data = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (bus.select_src == SW'(s)) begin
                w_wr_data = bus.src_data[s];
            end
        end
    end

    // Clear FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RF_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Clear FSM next state: one register per cycle, leave after the last one.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RF_IDLE:  if (bus.clear_req) w_next_state = RF_CLEAR;
            RF_CLEAR: if (w_clr_last)    w_next_state = RF_IDLE;
            default:                     w_next_state = RF_IDLE;
        endcase
    end

    // Clear FSM outputs; external writes are only accepted while idle.
    always_comb begin
        bus.clear_busy = (r_state == RF_CLEAR);
        bus.clear_done = (r_state == RF_CLEAR) && w_clr_last;
        w_wr_accept    = (r_state == RF_IDLE) && bus.write_en;
    end

    // Clear pointer parks at zero while idle so a new clear always starts at register 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_ptr <= '0;
        end else if (r_state == RF_IDLE) begin
            r_clr_ptr <= '0;
        end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
        end
    end

    // Storage: clear engine owns the array while active, otherwise accepted writes land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= {N{rf_reset_val(i, ONES_IDX)}};
            end
        end else if (r_state == RF_CLEAR) begin
            r_q[r_clr_ptr] <= {N{rf_reset_val(int'(r_clr_ptr), ONES_IDX)}};
        end else if (w_wr_accept) begin
            r_q[bus.write_addr] <= w_wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        assign w_rd_data[p] = r_q[bus.read_addr[p]];

        rf_read_port #(
            .N  (N),
            .AW (AW)
        ) u_rd_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_rd_en    (bus.read_en[p]),
            .i_rd_addr  (bus.read_addr[p]),
            .i_sel_dest (bus.select_dest[p]),
            .i_rd_data  (w_rd_data[p]),
            .i_wr_en    (w_wr_accept),
            .i_wr_addr  (bus.write_addr),
            .i_wr_data  (w_wr_data),
            .o_dest1    (bus.dest1[p]),
            .o_dest2    (bus.dest2[p]),
            .o_rd_valid (bus.rd_valid[p])
        );
    end
endmodule
